// File: rtl/fft_frame_sequencer.sv
// Frame controller for the 8-point real-input FFT: gathers 8 samples, waits out the
// datapath latency, snapshots the 14 result words and streams them out one per handshake.
module fft_frame_sequencer #(
    parameter int FFT_LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         abort,
    output logic [63:0]  x_flat,
    input  logic [167:0] a_flat,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [11:0]  out_data,
    output logic [3:0]   out_idx,
    output logic         out_last,
    output logic         busy,
    output logic [7:0]   frame_cnt
);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_WAIT   = 2'd1,
        S_UNLOAD = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LOAD = 8'(FFT_LAT);

    state_t         state_r, state_s;
    logic [2:0]     count_r, count_s;
    logic [7:0]     wait_cnt_r, wait_cnt_s;
    logic [63:0]    x_r, x_s;
    logic [167:0]   buf_r, buf_s;
    logic [3:0]     idx_r, idx_s;
    logic [7:0]     frame_cnt_r, frame_cnt_s;
    logic           in_ready_r, out_valid_r, out_last_r, busy_r;
    logic [11:0]    out_data_r;

    function automatic logic [11:0] word_sel(input logic [167:0] b, input logic [3:0] j);
        logic [11:0] w;
        w = 12'd0;
        for (int i = 0; i < 14; i++) begin
            w = (j == 4'(i)) ? b[12*i +: 12] : w;
        end
        return w;
    endfunction

    // Next-state and next-value logic for the whole frame sequence
    always_comb begin
        state_s     = state_r;
        count_s     = count_r;
        wait_cnt_s  = wait_cnt_r;
        x_s         = x_r;
        buf_s       = buf_r;
        idx_s       = idx_r;
        frame_cnt_s = frame_cnt_r;
        if (abort) begin
            state_s = S_LOAD;
            count_s = 3'd0;
            idx_s   = 4'd0;
        end else begin
            case (state_r)
                S_LOAD: begin
                    if (in_valid) begin
                        for (int i = 0; i < 8; i++) begin
                            x_s[8*i +: 8] = (count_r == 3'(i)) ? in_data : x_r[8*i +: 8];
                        end
                        if (count_r == 3'd7) begin
                            count_s    = 3'd0;
                            wait_cnt_s = WAIT_LOAD;
                            state_s    = S_WAIT;
                        end else begin
                            count_s = count_r + 3'd1;
                        end
                    end else begin
                        count_s = count_r;
                    end
                end
                S_WAIT: begin
                    // a_flat reflects the new x_flat once the counter has drained
                    if (wait_cnt_r == 8'd0) begin
                        buf_s   = a_flat;
                        idx_s   = 4'd0;
                        state_s = S_UNLOAD;
                    end else begin
                        wait_cnt_s = wait_cnt_r - 8'd1;
                    end
                end
                S_UNLOAD: begin
                    if (out_ready) begin
                        if (idx_r == 4'd13) begin
                            frame_cnt_s = frame_cnt_r + 8'd1;
                            idx_s       = 4'd0;
                            state_s     = S_LOAD;
                        end else begin
                            idx_s = idx_r + 4'd1;
                        end
                    end else begin
                        idx_s = idx_r;
                    end
                end
                default: begin
                    state_s = S_LOAD;
                    count_s = 3'd0;
                    idx_s   = 4'd0;
                end
            endcase
        end
    end

    // State, datapath and output registers; outputs are decoded from next-state values
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= S_LOAD;
            count_r     <= 3'd0;
            wait_cnt_r  <= 8'd0;
            x_r         <= 64'd0;
            buf_r       <= 168'd0;
            idx_r       <= 4'd0;
            frame_cnt_r <= 8'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            out_data_r  <= 12'd0;
        end else begin
            state_r     <= state_s;
            count_r     <= count_s;
            wait_cnt_r  <= wait_cnt_s;
            x_r         <= x_s;
            buf_r       <= buf_s;
            idx_r       <= idx_s;
            frame_cnt_r <= frame_cnt_s;
            in_ready_r  <= (state_s == S_LOAD);
            out_valid_r <= (state_s == S_UNLOAD);
            out_last_r  <= (state_s == S_UNLOAD) && (idx_s == 4'd13);
            busy_r      <= (state_s != S_LOAD);
            out_data_r  <= word_sel(buf_s, idx_s);
        end
    end

    assign in_ready  = in_ready_r;
    assign x_flat    = x_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_idx   = idx_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;
    assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with a 2-stage integer FFT model on a_flat.
module tb_fft_frame_sequencer;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, abort, out_valid, out_ready, out_last, busy;
    logic [7:0]   in_data, frame_cnt;
    logic [63:0]  x_flat;
    logic [167:0] a_flat = '0;
    logic [167:0] st1 = '0;
    logic [11:0]  out_data;
    logic [3:0]   out_idx;

    int           tests_run = 0;
    int           tests_failed = 0;
    logic [7:0]   exp_fc;
    logic [11:0]  got_w [14];
    int           col_errs, col_cycles;

    fft_frame_sequencer #(.FFT_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .abort(abort), .x_flat(x_flat), .a_flat(a_flat),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic int cmul(input int d);
        return (d * 181) >>> 8;
    endfunction

    // Integer DFT of 8 real samples, words packed in j order
    function automatic logic [167:0] fft_model(input logic [63:0] x);
        int v [8];
        int w [14];
        int t;
        logic [167:0] r;
        for (int i = 0; i < 8; i++) v[i] = int'(x[8*i +: 8]);
        w[0]  = v[0]+v[1]+v[2]+v[3]+v[4]+v[5]+v[6]+v[7];
        w[1]  = v[0]-v[4] + cmul(v[1]-v[3]-v[5]+v[7]);
        w[2]  = -(v[2]-v[6]) - cmul(v[1]+v[3]-v[5]-v[7]);
        w[3]  = v[0]-v[2]+v[4]-v[6];
        w[4]  = -(v[1]-v[3]+v[5]-v[7]);
        w[5]  = v[0]-v[4] + cmul(-v[1]+v[3]+v[5]-v[7]);
        w[6]  = (v[2]-v[6]) - cmul(v[1]+v[3]-v[5]-v[7]);
        w[7]  = v[0]-v[1]+v[2]-v[3]+v[4]-v[5]+v[6]-v[7];
        w[8]  = w[5];
        w[9]  = -w[6];
        w[10] = w[3];
        w[11] = -w[4];
        w[12] = w[1];
        w[13] = -w[2];
        r = '0;
        for (int j = 0; j < 14; j++) begin
            t = w[j];
            r[12*j +: 12] = t[11:0];
        end
        return r;
    endfunction

    // Datapath model: one compute stage plus an output register
    always @(posedge clk) begin
        st1    <= fft_model(x_flat);
        a_flat <= st1;
    end

    task automatic push(input logic [7:0] d);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests_run++; tests_failed++;
            $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input bit rnd);
        int  next_j;
        bit  done, prev_stall;
        logic [11:0] pd;
        logic [3:0]  pi;
        col_errs = 0; col_cycles = 0; next_j = 0; done = 1'b0; prev_stall = 1'b0;
        pd = '0; pi = '0;
        for (int j = 0; j < 14; j++) got_w[j] = 12'hBAD;
        while (!done && col_cycles < 400) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid === 1'b1) begin
                if (prev_stall && (out_data !== pd || out_idx !== pi)) col_errs++;
                if (in_ready !== 1'b0) col_errs++;
                if (out_last !== (out_idx == 4'd13)) col_errs++;
                if (out_ready) begin
                    if (out_idx !== 4'(next_j)) col_errs++;
                    got_w[out_idx] = out_data;
                    next_j++;
                    if (out_idx == 4'd13) done = 1'b1;
                end
                prev_stall = !out_ready;
                pd = out_data;
                pi = out_idx;
            end else begin
                prev_stall = 1'b0;
            end
            @(negedge clk);
            col_cycles++;
        end
        out_ready = 1'b0;
        if (!done) col_errs += 1000;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hAA; abort = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        exp_fc = 8'd0;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        tests_run++; if ({out_valid, out_last, busy} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags: got %b required 000", {out_valid, out_last, busy}); end
        tests_run++; if (x_flat !== 64'd0) begin tests_failed++; $display("FAIL reset_x_flat: got %h required 0", x_flat); end
        tests_run++; if ({frame_cnt, out_idx, out_data} !== 24'd0) begin tests_failed++; $display("FAIL reset_counters: got %h required 0", {frame_cnt, out_idx, out_data}); end
    endtask

    task automatic test_single_frame();
        logic [167:0] e;
        for (int k = 0; k < 8; k++) push(8'(k + 1));
        tests_run++; if (x_flat !== 64'h0807060504030201) begin tests_failed++; $display("FAIL single_x_flat: got %h required 0807060504030201", x_flat); end
        tests_run++; if ({out_valid, busy, in_ready} !== 3'b010) begin tests_failed++; $display("FAIL single_wait0: got %b required 010", {out_valid, busy, in_ready}); end
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_wait1: got %b required 0", out_valid); end
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_wait2: got %b required 0", out_valid); end
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b1 || out_idx !== 4'd0) begin tests_failed++; $display("FAIL single_latency: got valid=%b idx=%0d required 1/0", out_valid, out_idx); end
        collect(1'b0);
        exp_fc++;
        tests_run++; if (col_errs != 0 || col_cycles != 14) begin tests_failed++; $display("FAIL single_stream: got errs=%0d cycles=%0d required 0/14", col_errs, col_cycles); end
        tests_run++; if (got_w[0] !== 12'd36) begin tests_failed++; $display("FAIL single_a0_re: got %h required 024", got_w[0]); end
        tests_run++; if (got_w[7] !== 12'hFFC) begin tests_failed++; $display("FAIL single_a4_re: got %h required FFC", got_w[7]); end
        e = fft_model(64'h0807060504030201);
        for (int j = 0; j < 14; j++) begin
            tests_run++; if (got_w[j] !== e[12*j +: 12]) begin tests_failed++; $display("FAIL single_word%0d: got %h required %h", j, got_w[j], e[12*j +: 12]); end
        end
        tests_run++; if (frame_cnt !== exp_fc || in_ready !== 1'b1 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_end: got fc=%0d rdy=%b vld=%b required %0d/1/0", frame_cnt, in_ready, out_valid, exp_fc); end
    endtask

    task automatic test_backpressure();
        logic [63:0]  x;
        logic [167:0] e;
        x = 64'h7F00AA550FF00180;
        for (int k = 0; k < 8; k++) push(x[8*k +: 8]);
        collect(1'b1);
        exp_fc++;
        tests_run++; if (col_errs != 0) begin tests_failed++; $display("FAIL bp_stream: got errs=%0d required 0", col_errs); end
        e = fft_model(x);
        for (int j = 0; j < 14; j++) begin
            tests_run++; if (got_w[j] !== e[12*j +: 12]) begin tests_failed++; $display("FAIL bp_word%0d: got %h required %h", j, got_w[j], e[12*j +: 12]); end
        end
        tests_run++; if (frame_cnt !== exp_fc || in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_end: got fc=%0d rdy=%b required %0d/1", frame_cnt, in_ready, exp_fc); end
    endtask

    task automatic test_gapped();
        logic [63:0] ex;
        int bad;
        ex = 64'h7F00AA550FF00180;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            repeat (2) begin
                @(negedge clk);
                if (x_flat !== ex) bad++;
            end
            push(8'hFF);
            ex[8*k +: 8] = 8'hFF;
            if (x_flat !== ex) bad++;
        end
        tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL gap_x_flat: got %0d bad samples required 0", bad); end
        collect(1'b0);
        exp_fc++;
        tests_run++; if (got_w[0] !== 12'd2040) begin tests_failed++; $display("FAIL gap_a0_re: got %0d required 2040", got_w[0]); end
        for (int j = 1; j < 14; j++) begin
            tests_run++; if (got_w[j] !== 12'd0) begin tests_failed++; $display("FAIL gap_word%0d: got %h required 000", j, got_w[j]); end
        end
    endtask

    task automatic test_abort();
        int n;
        for (int k = 0; k < 5; k++) push(8'h33);
        abort = 1'b1; in_valid = 1'b1; in_data = 8'h77;
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        tests_run++; if (x_flat !== 64'hFFFFFF3333333333 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL abort_load: got x=%h rdy=%b required FFFFFF3333333333/1", x_flat, in_ready); end
        for (int k = 0; k < 8; k++) push(8'h10);
        collect(1'b0);
        exp_fc++;
        tests_run++; if (got_w[0] !== 12'd128) begin tests_failed++; $display("FAIL abort_dc: got %0d required 128", got_w[0]); end
        tests_run++; if (got_w[7] !== 12'd0 || got_w[3] !== 12'd0) begin tests_failed++; $display("FAIL abort_ac: got %h/%h required 000/000", got_w[7], got_w[3]); end
        for (int k = 0; k < 8; k++) push(8'(k + 1));
        out_ready = 1'b1;
        n = 0;
        while (!(out_valid === 1'b1 && out_idx == 4'd6) && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests_run++; if (n >= 100) begin tests_failed++; $display("FAIL abort_reach_j6: got timeout required idx 6"); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; out_ready = 1'b0;
        tests_run++; if ({out_valid, busy, in_ready} !== 3'b001 || out_idx !== 4'd0) begin tests_failed++; $display("FAIL abort_unload: got vbr=%b idx=%0d required 001/0", {out_valid, busy, in_ready}, out_idx); end
        tests_run++; if (frame_cnt !== exp_fc || x_flat !== 64'h0807060504030201) begin tests_failed++; $display("FAIL abort_kept: got fc=%0d x=%h required %0d/0807060504030201", frame_cnt, x_flat, exp_fc); end
    endtask

    task automatic test_reset_wrap();
        int n;
        logic [63:0]  x;
        logic [167:0] e;
        for (int k = 0; k < 8; k++) push(8'(k + 1));
        out_ready = 1'b1;
        n = 0;
        while (!(out_valid === 1'b1 && out_idx == 4'd9) && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests_run++; if (n >= 100) begin tests_failed++; $display("FAIL wrap_reach_j9: got timeout required idx 9"); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b0;
        exp_fc = 8'd0;
        tests_run++; if ({out_valid, in_ready, busy} !== 3'b010 || frame_cnt !== 8'd0 || x_flat !== 64'd0) begin tests_failed++; $display("FAIL wrap_reset: got vrb=%b fc=%0d x=%h required 010/0/0", {out_valid, in_ready, busy}, frame_cnt, x_flat); end
        n = 0;
        for (int f = 0; f < 256; f++) begin
            for (int k = 0; k < 8; k++) push(8'(f + k));
            collect(1'b0);
            n += col_errs;
            exp_fc++;
            if (f == 254) begin
                tests_run++; if (frame_cnt !== 8'd255) begin tests_failed++; $display("FAIL wrap_255: got %0d required 255", frame_cnt); end
            end
        end
        tests_run++; if (frame_cnt !== 8'd0 || n != 0) begin tests_failed++; $display("FAIL wrap_0: got fc=%0d errs=%0d required 0/0", frame_cnt, n); end
        x = 64'h12C8F0073E9B5A64;
        for (int k = 0; k < 8; k++) push(x[8*k +: 8]);
        collect(1'b0);
        exp_fc++;
        e = fft_model(x);
        for (int j = 0; j < 14; j++) begin
            tests_run++; if (got_w[j] !== e[12*j +: 12]) begin tests_failed++; $display("FAIL restart_word%0d: got %h required %h", j, got_w[j], e[12*j +: 12]); end
        end
        tests_run++; if (frame_cnt !== exp_fc) begin tests_failed++; $display("FAIL restart_fc: got %0d required %0d", frame_cnt, exp_fc); end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'd0; abort = 1'b0; out_ready = 1'b0;
        exp_fc = 8'd0;
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_backpressure();
        test_gapped();
        test_abort();
        test_reset_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
